// File: rtl/cdb_arbiter_pkg.sv
// Shared defines for the result-broadcast path: CDB payload type and default sizing.
// Functional units, the arbiter and the reservation stations all import this package.
package cdb_arbiter_pkg;

    localparam int SRC_COUNT_DEF  = 4;
    localparam int CDB_COUNT_DEF  = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int XLEN       = 32;
    localparam int ROB_ID_W   = 5;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 4;

    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_LSU  = 2'd3
    } src_id_e;

    typedef enum logic [1:0] {
        LSU_BYTE  = 2'd0,
        LSU_HALF  = 2'd1,
        LSU_WORD  = 2'd2,
        LSU_DWORD = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        lsu_size_e size;
        logic      exception;
    } lsu_info_t;

    typedef struct packed {
        logic [XLEN-1:0]       w_data;
        logic [ROB_ID_W-1:0]   rob_id;
        logic [REG_ADDR_W-1:0] w_reg;
        logic                  r_valid;
        logic [CTRL_W-1:0]     ctrl;
        lsu_info_t             lsu_info;
    } cdb_info_t;

endpackage

// File: rtl/result_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO with registered occupancy.
// Ready depends only on the registered count, never on a same-cycle pop.
module result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      enq_valid,
    input  cdb_info_t enq_data,
    output logic      enq_ready,
    input  logic      deq,
    output logic      not_empty,
    output cdb_info_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    cdb_info_t mem [DEPTH];
    ptr_t      wr_ptr;
    ptr_t      rd_ptr;
    cnt_t      count;
    logic      clear;
    logic      do_enq;
    logic      do_deq;

    assign clear     = !rst_n || flush;
    assign enq_ready = (count < cnt_t'(DEPTH));
    assign not_empty = (count != '0);
    assign do_enq    = enq_valid && enq_ready;
    assign do_deq    = deq && not_empty;
    assign head      = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_deq) rd_ptr <= rd_ptr + ptr_t'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates visibility, so stale entries are never broadcast.
    always_ff @(posedge clk) begin
        if (do_enq && !clear) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers each functional unit's results and grants up to
// CDB_COUNT lanes per cycle in round-robin order starting at rr_ptr.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int SRC_COUNT  = SRC_COUNT_DEF,
    parameter int CDB_COUNT  = CDB_COUNT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  cdb_info_t [SRC_COUNT-1:0]      src_data_i,
    input  logic      [SRC_COUNT-1:0]      src_valid_i,
    output logic      [SRC_COUNT-1:0]      src_ready_o,
    output cdb_info_t [CDB_COUNT-1:0]      cdb_data_o,
    output logic      [CDB_COUNT-1:0]      cdb_valid_o
);

    localparam int RR_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

    typedef logic [RR_W-1:0] rr_t;

    rr_t                       rr_ptr;
    rr_t                       rr_next;
    logic      [SRC_COUNT-1:0] not_empty;
    logic      [SRC_COUNT-1:0] pop;
    cdb_info_t [SRC_COUNT-1:0] head;

    for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
        result_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .enq_valid (src_valid_i[s]),
            .enq_data  (src_data_i[s]),
            .enq_ready (src_ready_o[s]),
            .deq       (pop[s]),
            .not_empty (not_empty[s]),
            .head      (head[s])
        );
    end

    always_comb begin : grant_logic
        int src;
        int lane;
        // NOTE: every output of this block is defaulted up front so no path can infer a latch.
        cdb_data_o  = '0;
        cdb_valid_o = '0;
        pop         = '0;
        rr_next     = rr_ptr;
        src         = 0;
        lane        = 0;
        for (int i = 0; i < SRC_COUNT; i++) begin
            src = (int'(rr_ptr) + i) % SRC_COUNT;
            if (not_empty[src] && lane < CDB_COUNT) begin
                cdb_valid_o[lane] = 1'b1;
                cdb_data_o[lane]  = head[src];
                pop[src]          = 1'b1;
                rr_next           = rr_t'((src + 1) % SRC_COUNT);
                lane++;
            end
        end
    end

    // rr_next already equals rr_ptr when nothing was granted.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) rr_ptr <= '0;
        else                 rr_ptr <= rr_next;
    end

endmodule
